// File: rtl/surf_cout_pkg.sv
// Shared types and constants for the SURF COUT training checker.
package surf_cout_pkg;

  // Width of one ISERDES parallel beat.
  localparam int NIBBLE_W = 4;

  // SURF COUT training word. All 8 nibble rotations are distinct, so a
  // full-window match pins the nibble phase unambiguously.
  localparam logic [31:0] SURF_COUT_TRAIN_PATTERN = 32'hA55A6996;

  typedef enum logic [1:0] {
    SETTLE,
    HUNT,
    LOCKED
  } cout_chk_state_t;

endpackage

// File: rtl/surf_cout_train_checker.sv
// Sysclk-domain COUT training checker. Keeps a 32-bit sliding window for
// software capture, locks onto the training pattern, produces the bit-error
// strobe for the register core, and gates the nibble stream toward the TURF.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// SETTLE | ISERDES output not trusted yet (after reset or bitslip); count down
// HUNT   | looking for a full training word ending on the newest nibble
// LOCKED | nibble phase known; compare each nibble against the pattern
//
// biterr_o is held high outside LOCKED so an unaligned link counts at full
// rate during eye scans.
module surf_cout_train_checker
  import surf_cout_pkg::*;
#(
  parameter logic [31:0] TRAIN_PATTERN = SURF_COUT_TRAIN_PATTERN,
  parameter int          LOSS_COUNT    = 4,
  parameter int          SETTLE_CYCLES = 3
) (
  input  logic                sysclk_i,
  input  logic                sysclk_rstn_i,
  input  logic [NIBBLE_W-1:0] cout_nibble_i,
  input  logic                bitslip_i,
  input  logic                capture_i,
  input  logic                enable_i,
  output logic [31:0]         data_o,
  output logic                biterr_o,
  output logic                locked_o,
  output logic [NIBBLE_W-1:0] cout_o,
  output logic                cout_valid_o
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LOSS_LIM    = 4'(LOSS_COUNT);

  cout_chk_state_t     state;
  logic [3:0]          settle_cnt;
  logic [2:0]          ptr;
  logic [3:0]          miss;
  logic [31:0]         win;
  logic [31:0]         win_next;
  logic [NIBBLE_W-1:0] exp_nibble;
  logic                nib_mismatch;
  logic [3:0]          miss_sat;

  assign win_next     = {win[27:0], cout_nibble_i};
  assign nib_mismatch = (cout_nibble_i != exp_nibble);
  assign miss_sat     = (miss == LOSS_LIM) ? miss : miss + 4'd1;
  assign locked_o     = (state == LOCKED);

  // Expected nibble for the current pattern phase; ptr 0 is the MSB nibble.
  always_comb begin
    exp_nibble = TRAIN_PATTERN[31:28];
    case (ptr)
      3'd0:    exp_nibble = TRAIN_PATTERN[31:28];
      3'd1:    exp_nibble = TRAIN_PATTERN[27:24];
      3'd2:    exp_nibble = TRAIN_PATTERN[23:20];
      3'd3:    exp_nibble = TRAIN_PATTERN[19:16];
      3'd4:    exp_nibble = TRAIN_PATTERN[15:12];
      3'd5:    exp_nibble = TRAIN_PATTERN[11:8];
      3'd6:    exp_nibble = TRAIN_PATTERN[7:4];
      3'd7:    exp_nibble = TRAIN_PATTERN[3:0];
      default: exp_nibble = TRAIN_PATTERN[31:28];
    endcase
  end

  // Sliding window and software capture; capture sees the pre-edge window.
  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) begin
      win    <= '0;
      data_o <= '0;
    end else begin
      win <= win_next;
      if (capture_i) begin
        data_o <= win;
      end
    end
  end

  // Lock FSM with registered bit-error strobe; bitslip overrides everything.
  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) begin
      state      <= SETTLE;
      settle_cnt <= SETTLE_LOAD;
      ptr        <= '0;
      miss       <= '0;
      biterr_o   <= 1'b1;
    end else if (bitslip_i) begin
      state      <= SETTLE;
      settle_cnt <= SETTLE_LOAD;
      miss       <= '0;
      biterr_o   <= 1'b1;
    end else begin
      case (state)
        SETTLE: begin
          biterr_o <= 1'b1;
          if (settle_cnt == 4'd0) begin
            state <= HUNT;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        HUNT: begin
          biterr_o <= 1'b1;
          if (win_next == TRAIN_PATTERN) begin
            state <= LOCKED;
            ptr   <= '0;
            miss  <= '0;
          end
        end
        LOCKED: begin
          ptr      <= ptr + 3'd1;
          biterr_o <= nib_mismatch;
          if (nib_mismatch) begin
            miss <= miss_sat;
            if (miss_sat == LOSS_LIM) begin
              state <= HUNT;
            end
          end else begin
            miss <= '0;
          end
        end
        default: begin
          state      <= SETTLE;
          settle_cnt <= SETTLE_LOAD;
          miss       <= '0;
          biterr_o   <= 1'b1;
        end
      endcase
    end
  end

  // TURF forwarding, gated only by the software enable.
  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) begin
      cout_o       <= '0;
      cout_valid_o <= 1'b0;
    end else begin
      cout_o       <= enable_i ? cout_nibble_i : '0;
      cout_valid_o <= enable_i;
    end
  end

endmodule

// File: tb/tb_surf_cout_train_checker.sv
// Self-checking bench for surf_cout_train_checker: behavioural model plus
// directed scenarios with literal expectations.
module tb_surf_cout_train_checker;

  localparam int          SETTLE_N = 3;
  localparam int          LOSS_N   = 4;
  localparam logic [31:0] PAT      = 32'hA55A6996;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  nib = 4'h0;
  logic        bs = 1'b0;
  logic        cap = 1'b0;
  logic        en = 1'b0;
  logic [31:0] data_o;
  logic        biterr_o;
  logic        locked_o;
  logic [3:0]  cout_o;
  logic        cout_valid_o;

  int n_vec = 0;
  int n_err = 0;
  int pidx = 0;

  logic [3:0] pat_n [8] = '{4'hA, 4'h5, 4'h5, 4'hA, 4'h6, 4'h9, 4'h9, 4'h6};

  // model state
  logic [3:0]  q [$];
  logic [31:0] m_data = '0;
  logic        m_biterr = 1'b1;
  logic        m_locked = 1'b0;
  logic [3:0]  m_cout = '0;
  logic        m_valid = 1'b0;
  int          settle_left = SETTLE_N;
  int          misses = 0;
  int          phase = 0;

  surf_cout_train_checker dut (
    .sysclk_i      (clk),
    .sysclk_rstn_i (rst_n),
    .cout_nibble_i (nib),
    .bitslip_i     (bs),
    .capture_i     (cap),
    .enable_i      (en),
    .data_o        (data_o),
    .biterr_o      (biterr_o),
    .locked_o      (locked_o),
    .cout_o        (cout_o),
    .cout_valid_o  (cout_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] win_of();
    logic [31:0] w = '0;
    for (int i = 0; i < q.size(); i++) w = {w[27:0], q[i]};
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: what the outputs must be after each edge.
  initial begin
    logic [31:0] old_w, new_w;
    logic        bad;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_data = '0; m_biterr = 1'b1; m_locked = 1'b0; m_cout = '0; m_valid = 1'b0;
        settle_left = SETTLE_N; misses = 0; phase = 0;
      end else begin
        old_w = win_of();
        if (cap) m_data = old_w;
        m_cout  = en ? nib : 4'h0;
        m_valid = en;
        q.push_back(nib);
        if (q.size() > 8) void'(q.pop_front());
        new_w = win_of();
        if (bs) begin
          settle_left = SETTLE_N; m_locked = 1'b0; misses = 0; m_biterr = 1'b1;
        end else if (settle_left > 0) begin
          settle_left--; m_biterr = 1'b1;
        end else if (!m_locked) begin
          m_biterr = 1'b1;
          if (new_w == PAT) begin
            m_locked = 1'b1; phase = 0; misses = 0;
          end
        end else begin
          bad = (nib != pat_n[phase]);
          m_biterr = bad;
          phase = (phase + 1) % 8;
          if (bad) begin
            misses++;
            if (misses >= LOSS_N) m_locked = 1'b0;
          end else begin
            misses = 0;
          end
        end
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("data", data_o, m_data);
      chk("biterr", 32'(biterr_o), 32'(m_biterr));
      chk("locked", 32'(locked_o), 32'(m_locked));
      chk("cout", 32'(cout_o), 32'(m_cout));
      chk("cout_valid", 32'(cout_valid_o), 32'(m_valid));
    end
  end

  task automatic cyc(input logic [3:0] n, input logic b, input logic c);
    nib = n; bs = b; cap = c;
    @(negedge clk);
    bs = 1'b0; cap = 1'b0;
  endtask

  task automatic feed_pat();
    cyc(pat_n[pidx % 8], 1'b0, 1'b0);
    pidx++;
  endtask

  task automatic advance_to(input int ph);
    while (pidx % 8 != ph) feed_pat();
  endtask

  initial begin
    logic [3:0] sent;
    #1 rst_n = 1'b0;
    repeat (3) cyc(4'($urandom_range(0, 15)), 1'b0, 1'b0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_biterr", 32'(biterr_o), 32'd1);
    chk("rst_locked", 32'(locked_o), 32'd0);
    chk("rst_cout", 32'(cout_o), 32'd0);
    chk("rst_valid", 32'(cout_valid_o), 32'd0);
    rst_n = 1'b1;

    // settle then lock on the 8th pattern nibble
    for (int j = 0; j < 8; j++) begin
      feed_pat();
      if (j < 3) chk("settle_biterr", 32'(biterr_o), 32'd1);
      if (j == 6) chk("prelock", 32'(locked_o), 32'd0);
      if (j == 7) chk("lock", 32'(locked_o), 32'd1);
    end
    feed_pat();
    chk("lock_biterr0", 32'(biterr_o), 32'd0);
    repeat (14) feed_pat();

    // single corrupted nibble: 6 -> 7
    advance_to(4);
    cyc(4'h7, 1'b0, 1'b0); pidx++;
    chk("single_err_biterr", 32'(biterr_o), 32'd1);
    chk("single_err_locked", 32'(locked_o), 32'd1);
    feed_pat();
    chk("single_err_clear", 32'(biterr_o), 32'd0);

    // loss of lock after four consecutive errors
    advance_to(4);
    for (int i = 0; i < 4; i++) begin
      cyc(pat_n[pidx % 8] ^ 4'hF, 1'b0, 1'b0); pidx++;
      chk("loss_biterr", 32'(biterr_o), 32'd1);
      chk("loss_locked", 32'(locked_o), (i < 3) ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= 8; k++) begin
      feed_pat();
      chk("relock", 32'(locked_o), (k == 8) ? 32'd1 : 32'd0);
    end

    // plain capture at word-aligned phase
    cyc(pat_n[pidx % 8], 1'b0, 1'b1); pidx++;
    chk("capture", data_o, 32'hA55A6996);

    // bitslip and capture together
    advance_to(4);
    cyc(pat_n[pidx % 8], 1'b1, 1'b1); pidx++;
    chk("slip_capture", data_o, 32'h6996A55A);
    chk("slip_locked", 32'(locked_o), 32'd0);
    chk("slip_biterr", 32'(biterr_o), 32'd1);
    repeat (2) begin
      feed_pat();
      chk("slip_settle_biterr", 32'(biterr_o), 32'd1);
      chk("slip_settle_locked", 32'(locked_o), 32'd0);
    end
    repeat (16) feed_pat();
    chk("slip_relock", 32'(locked_o), 32'd1);

    // final loss mismatch coinciding with bitslip: settle wins
    advance_to(0);
    repeat (3) begin
      cyc(pat_n[pidx % 8] ^ 4'hF, 1'b0, 1'b0); pidx++;
    end
    cyc(pat_n[pidx % 8] ^ 4'hF, 1'b1, 1'b0); pidx++;
    chk("loss_slip_locked", 32'(locked_o), 32'd0);
    repeat (19) feed_pat();
    chk("loss_slip_relock", 32'(locked_o), 32'd1);

    // enable gating
    en = 1'b1;
    repeat (3) begin
      sent = pat_n[pidx % 8];
      feed_pat();
      chk("en_cout", 32'(cout_o), 32'(sent));
      chk("en_valid", 32'(cout_valid_o), 32'd1);
    end
    en = 1'b0;
    feed_pat();
    chk("dis_cout", 32'(cout_o), 32'd0);
    chk("dis_valid", 32'(cout_valid_o), 32'd0);

    // async reset mid-operation
    en = 1'b1;
    feed_pat();
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", data_o, 32'h0);
    chk("mid_rst_biterr", 32'(biterr_o), 32'd1);
    chk("mid_rst_locked", 32'(locked_o), 32'd0);
    chk("mid_rst_cout", 32'(cout_o), 32'd0);
    chk("mid_rst_valid", 32'(cout_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      feed_pat();
      chk("post_rst_settle", 32'(biterr_o), 32'd1);
    end
    repeat (16) feed_pat();
    chk("post_rst_relock", 32'(locked_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
